// File: rtl/opmem_pkg.sv
// opmem_pkg: shared constants and types for the opcode-memory arbiter.
//   OPMEM_AW / OPMEM_DW : opmem geometry (8 entries x 8 bits)
//   state_e             : arbiter top-level state (clear sweep / normal service)
//   port_e              : requester identity, used for the round-robin pointer
package opmem_pkg;

  localparam int unsigned OPMEM_AW = 3;
  localparam int unsigned OPMEM_DW = 8;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_e;

  // Port that gets priority after the given port has been served.
  function automatic port_e other_port(port_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/opmem_arbiter_if.sv
// opmem_arbiter_if: requester-side bundle for the two opmem clients.
//   a_* / b_*  : valid/we/addr/wdata request, ready accept, rvalid response
//   rdata      : read data shared by both ports, qualified by a_rvalid/b_rvalid
// Modports:
//   master : requester view (drives requests, observes handshake/response)
//   slave  : arbiter view
interface opmem_arbiter_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
);

  logic          a_valid;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ready;
  logic          a_rvalid;

  logic          b_valid;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ready;
  logic          b_rvalid;

  logic [DW-1:0] rdata;

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    output b_valid, b_we, b_addr, b_wdata,
    input  a_ready, a_rvalid, b_ready, b_rvalid, rdata
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    input  b_valid, b_we, b_addr, b_wdata,
    output a_ready, a_rvalid, b_ready, b_rvalid, rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with its own priority pointer.
//   clk, reset : clock, synchronous active-high reset (pointer -> PORT_A)
//   req[1:0]   : request vector, bit 0 = port A, bit 1 = port B
//   advance    : allow the pointer to move when a grant is issued
//   gnt[1:0]   : one-hot (or zero) grant, combinational from req and pointer
module rr_arb2
  import opmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_e ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;

    if (req == 2'b11) begin
      // Contention: the pointer names the winner.
      gnt = (ptr_q == PORT_A) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end

    // Priority goes to whichever port was not just served.
    if (advance && (gnt != 2'b00)) begin
      ptr_d = other_port(gnt[0] ? PORT_A : PORT_B);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= PORT_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/opmem_arbiter.sv
// opmem_arbiter: shares the single-port 8x8 opcode RAM between a loader/host
// port (A) and a fetch/execute port (B).
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : both requesters' valid/ready requests and read responses
//   init_done         : clear sweep finished, requests are now served
//   mem_ce/oce/wre    : opmem chip enable / output enable / write enable
//   mem_reset         : opmem reset, follows reset
//   mem_ad, mem_din   : opmem address and write data
//   mem_dout          : opmem read data, valid one cycle after a read access
// At most one access per cycle; round-robin on contention. Read data comes back
// one cycle after the grant, tagged by a_rvalid or b_rvalid.
module opmem_arbiter
  import opmem_pkg::*;
#(
  parameter int unsigned   AW             = OPMEM_AW,
  parameter int unsigned   DW             = OPMEM_DW,
  parameter bit            CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0] CLEAR_VALUE    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  opmem_arbiter_if.slave       bus,
  output logic                 init_done,
  output logic                 mem_ce,
  output logic                 mem_oce,
  output logic                 mem_wre,
  output logic                 mem_reset,
  output logic [AW-1:0]        mem_ad,
  output logic [DW-1:0]        mem_din,
  input  logic [DW-1:0]        mem_dout
);

  localparam state_e ResetState = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          rv_a_q, rv_a_d;
  logic          rv_b_q, rv_b_d;
  logic          run;
  logic [1:0]    gnt;

  // Requests are only considered in RUN and never while reset is asserted,
  // so nothing is accepted that the reset would then silently discard.
  assign run = (state_q == ST_RUN) && !reset;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({bus.b_valid, bus.a_valid} & {2{run}}),
    .advance (run),
    .gnt     (gnt)
  );

  assign bus.a_ready = gnt[0];
  assign bus.b_ready = gnt[1];

  // A response launched just before reset must not be seen by a requester.
  assign bus.a_rvalid = rv_a_q && !reset;
  assign bus.b_rvalid = rv_b_q && !reset;
  assign bus.rdata    = mem_dout;

  assign init_done = done_q;
  assign mem_oce   = 1'b1;
  assign mem_reset = reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    rv_a_d  = 1'b0;
    rv_b_d  = 1'b0;
    mem_ce  = 1'b0;
    mem_wre = 1'b0;
    mem_ad  = '0;
    mem_din = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_ce  = 1'b1;
        mem_wre = 1'b1;
        mem_ad  = cnt_q;
        mem_din = CLEAR_VALUE;
        cnt_d   = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end

      ST_RUN: begin
        if (gnt[0]) begin
          mem_ce  = 1'b1;
          mem_wre = bus.a_we;
          mem_ad  = bus.a_addr;
          mem_din = bus.a_wdata;
          rv_a_d  = !bus.a_we;
        end else if (gnt[1]) begin
          mem_ce  = 1'b1;
          mem_wre = bus.b_we;
          mem_ad  = bus.b_addr;
          mem_din = bus.b_wdata;
          rv_b_d  = !bus.b_we;
        end
      end

      default: begin
        state_d = ResetState;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      done_q  <= ~CLEAR_ON_RESET;
      rv_a_q  <= 1'b0;
      rv_b_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rv_a_q  <= rv_a_d;
      rv_b_q  <= rv_b_d;
    end
  end

endmodule

// File: tb/tb_opmem_arbiter.sv
// Self-checking bench for opmem_arbiter: clear sweep, hold-off, a vector table
// for grants/responses, a mid-operation reset, then randomized traffic against
// a request-level reference model.
module tb_opmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  opmem_arbiter_if #(.AW(3), .DW(8)) bus ();
  opmem_arbiter_if #(.AW(3), .DW(8)) bus_nc ();

  logic       init_done, mem_ce, mem_oce, mem_wre, mem_reset;
  logic [2:0] mem_ad;
  logic [7:0] mem_din, mem_dout;
  logic       nc_init_done, nc_ce, nc_oce, nc_wre, nc_reset;
  logic [2:0] nc_ad;
  logic [7:0] nc_din;

  opmem_arbiter #(.AW(3), .DW(8), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .init_done (init_done),
    .mem_ce    (mem_ce),
    .mem_oce   (mem_oce),
    .mem_wre   (mem_wre),
    .mem_reset (mem_reset),
    .mem_ad    (mem_ad),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  opmem_arbiter #(.AW(3), .DW(8), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(8'h00)) u_nc (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_nc),
    .init_done (nc_init_done),
    .mem_ce    (nc_ce),
    .mem_oce   (nc_oce),
    .mem_wre   (nc_wre),
    .mem_reset (nc_reset),
    .mem_ad    (nc_ad),
    .mem_din   (nc_din),
    .mem_dout  (8'h00)
  );

  // opmem stand-in: registered read (1-cycle latency), write committed at edge.
  logic [7:0] ram [8];
  always @(posedge clk) begin
    if (mem_reset) mem_dout <= 8'h00;
    else if (mem_ce && mem_oce && !mem_wre) mem_dout <= ram[mem_ad];
    if (mem_ce && mem_oce && mem_wre) ram[mem_ad] <= mem_din;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_a(input logic v, input logic we, input logic [2:0] ad, input logic [7:0] d);
    bus.a_valid = v; bus.a_we = we; bus.a_addr = ad; bus.a_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [2:0] ad, input logic [7:0] d);
    bus.b_valid = v; bus.b_we = we; bus.b_addr = ad; bus.b_wdata = d;
  endtask

  typedef struct {
    logic av; logic awe; logic [2:0] aad; logic [7:0] ad;
    logic bv; logic bwe; logic [2:0] bad_; logic [7:0] bd;
    logic ardy; logic brdy; logic ce; logic wre; logic [2:0] mad; logic [7:0] din;
    logic arv; logic brv; logic [7:0] rd;
  } vec_t;

  vec_t vecs [12];

  // Reference model state
  logic       pa_v, pa_we, pb_v, pb_we;
  logic [2:0] pa_ad, pb_ad;
  logic [7:0] pa_d, pb_d;
  logic [7:0] ref_mem [8];
  logic       exp_arv, exp_brv, a_win, b_win;
  logic [7:0] exp_rd;
  int         prio;

  initial begin
    // av awe aad ad  bv bwe bad bd  | ardy brdy ce wre mad din  arv brv rd
    vecs[0]  = '{1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00,
                 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00,
                 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 8'hA5};
    vecs[2]  = '{1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00,
                 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b1, 8'hA5};
    vecs[3]  = '{1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00,
                 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 8'hA5};
    vecs[4]  = '{1'b1, 1'b1, 3'd5, 8'h3C, 1'b0, 1'b0, 3'd0, 8'h00,
                 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'h3C, 1'b0, 1'b1, 8'hA5};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00,
                 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 3'd7, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00,
                 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 8'hFF, 1'b0, 1'b1, 8'h3C};
    vecs[7]  = '{1'b1, 1'b1, 3'd0, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00,
                 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00,
                 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00,
                 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFF};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00,
                 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h01};
    vecs[11] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00,
                 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00};

    set_a(1'b0, 1'b0, 3'd0, 8'h00);
    set_b(1'b0, 1'b0, 3'd0, 8'h00);
    bus_nc.a_valid = 1'b0; bus_nc.a_we = 1'b0; bus_nc.a_addr = 3'd0; bus_nc.a_wdata = 8'h00;
    bus_nc.b_valid = 1'b0; bus_nc.b_we = 1'b0; bus_nc.b_addr = 3'd0; bus_nc.b_wdata = 8'h00;

    // Power-up reset for one cycle, then both ports request during the clear.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_a(1'b1, 1'b0, 3'd3, 8'h00);
    set_b(1'b1, 1'b0, 3'd6, 8'h00);
    bus_nc.a_valid = 1'b1; bus_nc.a_addr = 3'd2;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk($sformatf("clr%0d.ce", i), 32'(mem_ce), 1);
      chk($sformatf("clr%0d.wre", i), 32'(mem_wre), 1);
      chk($sformatf("clr%0d.ad", i), 32'(mem_ad), i);
      chk($sformatf("clr%0d.din", i), 32'(mem_din), 32'h A5);
      chk($sformatf("clr%0d.init_done", i), 32'(init_done), 0);
      chk($sformatf("clr%0d.a_ready", i), 32'(bus.a_ready), 0);
      chk($sformatf("clr%0d.b_ready", i), 32'(bus.b_ready), 0);
      if (i == 0) begin
        chk("noclr.init_done", 32'(nc_init_done), 1);
        chk("noclr.a_ready", 32'(bus_nc.a_ready), 1);
        chk("noclr.ad", 32'(nc_ad), 2);
      end
      tick();
      bus_nc.a_valid = 1'b0;
    end
    settle();
    chk("run0.init_done", 32'(init_done), 1);
    chk("run0.a_ready", 32'(bus.a_ready), 1);
    chk("run0.b_ready", 32'(bus.b_ready), 0);
    chk("run0.ad", 32'(mem_ad), 3);
    chk("run0.wre", 32'(mem_wre), 0);
    tick();
    set_a(1'b0, 1'b0, 3'd0, 8'h00);
    settle();
    chk("run1.b_ready", 32'(bus.b_ready), 1);
    chk("run1.ad", 32'(mem_ad), 6);
    chk("run1.a_rvalid", 32'(bus.a_rvalid), 1);
    chk("run1.b_rvalid", 32'(bus.b_rvalid), 0);
    chk("run1.rdata", 32'(bus.rdata), 32'h A5);
    tick();
    set_b(1'b0, 1'b0, 3'd0, 8'h00);
    settle();
    chk("run2.a_rvalid", 32'(bus.a_rvalid), 0);
    chk("run2.b_rvalid", 32'(bus.b_rvalid), 1);
    chk("run2.rdata", 32'(bus.rdata), 32'h A5);
    tick();

    // Vector table: contention, single-port RAW, wrap addresses.
    for (int i = 0; i < 12; i++) begin
      set_a(vecs[i].av, vecs[i].awe, vecs[i].aad, vecs[i].ad);
      set_b(vecs[i].bv, vecs[i].bwe, vecs[i].bad_, vecs[i].bd);
      settle();
      chk($sformatf("vec%0d.a_ready", i), 32'(bus.a_ready), 32'(vecs[i].ardy));
      chk($sformatf("vec%0d.b_ready", i), 32'(bus.b_ready), 32'(vecs[i].brdy));
      chk($sformatf("vec%0d.ce", i), 32'(mem_ce), 32'(vecs[i].ce));
      chk($sformatf("vec%0d.a_rvalid", i), 32'(bus.a_rvalid), 32'(vecs[i].arv));
      chk($sformatf("vec%0d.b_rvalid", i), 32'(bus.b_rvalid), 32'(vecs[i].brv));
      if (vecs[i].ce) begin
        chk($sformatf("vec%0d.wre", i), 32'(mem_wre), 32'(vecs[i].wre));
        chk($sformatf("vec%0d.ad", i), 32'(mem_ad), 32'(vecs[i].mad));
        if (vecs[i].wre) chk($sformatf("vec%0d.din", i), 32'(mem_din), 32'(vecs[i].din));
      end
      if (vecs[i].arv || vecs[i].brv)
        chk($sformatf("vec%0d.rdata", i), 32'(bus.rdata), 32'(vecs[i].rd));
      tick();
    end

    // Reset in the cycle after a B read grant.
    set_a(1'b0, 1'b0, 3'd0, 8'h00);
    set_b(1'b1, 1'b0, 3'd2, 8'h00);
    settle();
    chk("mrst.b_ready", 32'(bus.b_ready), 1);
    tick();
    set_b(1'b0, 1'b0, 3'd0, 8'h00);
    reset = 1'b1;
    settle();
    chk("mrst.b_rvalid_in_reset", 32'(bus.b_rvalid), 0);
    tick();
    reset = 1'b0;
    set_a(1'b1, 1'b0, 3'd4, 8'h00);
    set_b(1'b1, 1'b0, 3'd5, 8'h00);
    for (int i = 0; i < 8; i++) begin
      settle();
      chk($sformatf("mrst.clr%0d.ad", i), 32'(mem_ad), i);
      chk($sformatf("mrst.clr%0d.b_rvalid", i), 32'(bus.b_rvalid), 0);
      if (i == 0) chk("mrst.init_done", 32'(init_done), 0);
      tick();
    end

    // Randomized traffic; first cycle continues the pending post-reset requests.
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'hA5;
    prio = 0;
    exp_arv = 1'b0; exp_brv = 1'b0; exp_rd = 8'h00;
    pa_v = 1'b1; pa_we = 1'b0; pa_ad = 3'd4; pa_d = 8'h00;
    pb_v = 1'b1; pb_we = 1'b0; pb_ad = 3'd5; pb_d = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if (!pa_v && $urandom_range(0, 3) != 0) begin
        pa_v = 1'b1; pa_we = 1'($urandom_range(0, 1));
        pa_ad = 3'($urandom_range(0, 7)); pa_d = 8'($urandom);
      end
      if (!pb_v && $urandom_range(0, 3) != 0) begin
        pb_v = 1'b1; pb_we = 1'($urandom_range(0, 1));
        pb_ad = 3'($urandom_range(0, 7)); pb_d = 8'($urandom);
      end
      set_a(pa_v, pa_we, pa_ad, pa_d);
      set_b(pb_v, pb_we, pb_ad, pb_d);
      settle();
      a_win = pa_v && (!pb_v || prio == 0);
      b_win = pb_v && !a_win;
      chk($sformatf("rnd%0d.a_ready", c), 32'(bus.a_ready), 32'(a_win));
      chk($sformatf("rnd%0d.b_ready", c), 32'(bus.b_ready), 32'(b_win));
      chk($sformatf("rnd%0d.ce", c), 32'(mem_ce), 32'(a_win || b_win));
      chk($sformatf("rnd%0d.a_rvalid", c), 32'(bus.a_rvalid), 32'(exp_arv));
      chk($sformatf("rnd%0d.b_rvalid", c), 32'(bus.b_rvalid), 32'(exp_brv));
      if (exp_arv || exp_brv) chk($sformatf("rnd%0d.rdata", c), 32'(bus.rdata), 32'(exp_rd));
      if (a_win) begin
        chk($sformatf("rnd%0d.a_ad", c), 32'(mem_ad), 32'(pa_ad));
        chk($sformatf("rnd%0d.a_wre", c), 32'(mem_wre), 32'(pa_we));
        if (pa_we) chk($sformatf("rnd%0d.a_din", c), 32'(mem_din), 32'(pa_d));
      end
      if (b_win) begin
        chk($sformatf("rnd%0d.b_ad", c), 32'(mem_ad), 32'(pb_ad));
        chk($sformatf("rnd%0d.b_wre", c), 32'(mem_wre), 32'(pb_we));
        if (pb_we) chk($sformatf("rnd%0d.b_din", c), 32'(mem_din), 32'(pb_d));
      end
      exp_arv = 1'b0;
      exp_brv = 1'b0;
      if (a_win) begin
        if (pa_we) ref_mem[pa_ad] = pa_d;
        else begin exp_arv = 1'b1; exp_rd = ref_mem[pa_ad]; end
        pa_v = 1'b0;
        prio = 1;
      end else if (b_win) begin
        if (pb_we) ref_mem[pb_ad] = pb_d;
        else begin exp_brv = 1'b1; exp_rd = ref_mem[pb_ad]; end
        pb_v = 1'b0;
        prio = 0;
      end
      tick();
    end

    set_a(1'b0, 1'b0, 3'd0, 8'h00);
    set_b(1'b0, 1'b0, 3'd0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
